// File: rtl/alu_seq_if.sv
// rtl/alu_seq_if.sv - request/response bundle between the EX stage and alu_seq
//
// Ports (master = pipeline side, slave = alu_seq):
//   in_valid/in_ready   request handshake
//   op[4:0]             operation select
//   read1, read2        operands A (rs1) and B (rs2/imm), XLEN bits
//   out_valid/out_ready result handshake
//   out                 registered result, XLEN bits
//   zero                out == 0
//   busy                iterative mul/div in progress
interface alu_seq_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [4:0]      op;
    logic [XLEN-1:0] read1;
    logic [XLEN-1:0] read2;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out;
    logic            zero;
    logic            busy;

    modport master (
        output in_valid, op, read1, read2, out_ready,
        input  in_ready, out_valid, out, zero, busy
    );

    modport slave (
        input  in_valid, op, read1, read2, out_ready,
        output in_ready, out_valid, out, zero, busy
    );
endinterface

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - handshaked RV ALU with iterative M-extension mul/div
//
// Base ops finish on the accept edge; mul/div run one bit per cycle for XLEN
// cycles, with sign correction folded into the last iteration.
// Optional feature macro: ALU_MULDIV_EN (undefined: M ops return 0 in 1 cycle).
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    alu_seq_if.slave (request, operands, result, zero, busy)
module alu_seq #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    alu_seq_if.slave   bus
);
    localparam int SHW = $clog2(XLEN);

    if (XLEN < 8 || (1 << CNT_W) <= XLEN) begin : g_bad_params
        $error("alu_seq: XLEN must be >= 8 and 2**CNT_W must exceed XLEN");
    end

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state, state_nxt;
    logic [XLEN-1:0] out_r, out_nxt;
    logic [XLEN-1:0] base_res;
    logic [SHW-1:0]  shamt;

    assign shamt = bus.read2[SHW-1:0];

    // Single-cycle RV base ops, evaluated straight off the request operands.
    always_comb begin
        base_res = '0;
        case (bus.op[3:0])
            4'd0:    base_res = bus.read1 & bus.read2;
            4'd1:    base_res = bus.read1 - bus.read2;
            4'd2:    base_res = bus.read1 << shamt;
            4'd3:    base_res = {{(XLEN-1){1'b0}}, $signed(bus.read1) < $signed(bus.read2)};
            4'd4:    base_res = {{(XLEN-1){1'b0}}, bus.read1 < bus.read2};
            4'd5:    base_res = bus.read1 ^ bus.read2;
            4'd6:    base_res = bus.read1 >> shamt;
            4'd7:    base_res = XLEN'($signed(bus.read1) >>> shamt);
            4'd8:    base_res = bus.read1 | bus.read2;
            4'd9:    base_res = bus.read1 + bus.read2;
            default: base_res = '0;
        endcase
    end

`ifdef ALU_MULDIV_EN
    // acc_hi/acc_lo hold {partial product hi, multiplier} for mul and
    // {partial remainder, dividend/quotient} for div; opb holds the
    // multiplicand or divisor magnitude.
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [2:0]       md_op, md_op_nxt;
    logic             neg_res, neg_res_nxt;
    logic             neg_rem, neg_rem_nxt;
    logic [XLEN-1:0]  acc_hi, acc_hi_nxt;
    logic [XLEN-1:0]  acc_lo, acc_lo_nxt;
    logic [XLEN-1:0]  opb, opb_nxt;

    logic            in_is_div, a_signed, b_signed, a_neg, b_neg;
    logic [XLEN-1:0] mag_a, mag_b;

    // op[2]=1 selects div/rem (signed when op[0]=0); for mul, MULHU is the
    // only op with unsigned A, and MULHSU/MULHU have unsigned B.
    assign in_is_div = bus.op[2];
    assign a_signed  = in_is_div ? ~bus.op[0] : (bus.op[1:0] != 2'b11);
    assign b_signed  = in_is_div ? ~bus.op[0] : ~bus.op[1];
    assign a_neg     = a_signed & bus.read1[XLEN-1];
    assign b_neg     = b_signed & bus.read2[XLEN-1];
    assign mag_a     = a_neg ? -bus.read1 : bus.read1;
    assign mag_b     = b_neg ? -bus.read2 : bus.read2;

    logic [XLEN:0]     mul_sum, div_trial;
    logic              div_ok;
    logic [XLEN-1:0]   step_hi, step_lo;
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   quot_s, rem_s, md_res;

    // Div trial subtract never overflows XLEN+1 bits because the partial
    // remainder is always below the divisor, so the top bit is the borrow.
    assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : '0);
    assign div_trial = {acc_hi, acc_lo[XLEN-1]} - {1'b0, opb};
    assign div_ok    = ~div_trial[XLEN];

    always_comb begin
        if (md_op[2]) begin
            step_hi = div_ok ? div_trial[XLEN-1:0] : {acc_hi[XLEN-2:0], acc_lo[XLEN-1]};
            step_lo = {acc_lo[XLEN-2:0], div_ok};
        end else begin
            step_hi = mul_sum[XLEN:1];
            step_lo = {mul_sum[0], acc_lo[XLEN-1:1]};
        end
    end

    // Sign fix-up on the values the final iteration produces. The signed
    // overflow case (-2^(XLEN-1) / -1) naturally yields read1 and rem 0.
    assign prod_s = neg_res ? -{step_hi, step_lo} : {step_hi, step_lo};
    assign quot_s = neg_res ? -step_lo : step_lo;
    assign rem_s  = neg_rem ? -step_hi : step_hi;

    always_comb begin
        if (md_op[2])
            md_res = md_op[1] ? rem_s : quot_s;
        else if (md_op[1:0] == 2'b00)
            md_res = prod_s[XLEN-1:0];
        else
            md_res = prod_s[2*XLEN-1:XLEN];
    end
`endif

    always_comb begin
        state_nxt = state;
        out_nxt   = out_r;
`ifdef ALU_MULDIV_EN
        cnt_nxt     = cnt;
        md_op_nxt   = md_op;
        neg_res_nxt = neg_res;
        neg_rem_nxt = neg_rem;
        acc_hi_nxt  = acc_hi;
        acc_lo_nxt  = acc_lo;
        opb_nxt     = opb;
`endif
        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    if (!bus.op[4]) begin
                        out_nxt   = base_res;
                        state_nxt = DONE;
                    end else begin
`ifdef ALU_MULDIV_EN
                        if (in_is_div && bus.read2 == '0) begin
                            out_nxt   = bus.op[1] ? bus.read1 : '1;
                            state_nxt = DONE;
                        end else begin
                            md_op_nxt   = bus.op[2:0];
                            neg_res_nxt = a_neg ^ b_neg;
                            neg_rem_nxt = a_neg;
                            opb_nxt     = in_is_div ? mag_b : mag_a;
                            acc_hi_nxt  = '0;
                            acc_lo_nxt  = in_is_div ? mag_a : mag_b;
                            cnt_nxt     = '0;
                            state_nxt   = BUSY;
                        end
`else
                        out_nxt   = '0;
                        state_nxt = DONE;
`endif
                    end
                end
            end
            BUSY: begin
`ifdef ALU_MULDIV_EN
                acc_hi_nxt = step_hi;
                acc_lo_nxt = step_lo;
                cnt_nxt    = cnt + 1'b1;
                if (cnt == CNT_W'(XLEN - 1)) begin
                    out_nxt   = md_res;
                    cnt_nxt   = '0;
                    state_nxt = DONE;
                end
`else
                state_nxt = IDLE;
`endif
            end
            DONE: begin
                if (bus.out_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            out_r <= '0;
`ifdef ALU_MULDIV_EN
            cnt     <= '0;
            md_op   <= '0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            acc_hi  <= '0;
            acc_lo  <= '0;
            opb     <= '0;
`endif
        end else begin
            state <= state_nxt;
            out_r <= out_nxt;
`ifdef ALU_MULDIV_EN
            cnt     <= cnt_nxt;
            md_op   <= md_op_nxt;
            neg_res <= neg_res_nxt;
            neg_rem <= neg_rem_nxt;
            acc_hi  <= acc_hi_nxt;
            acc_lo  <= acc_lo_nxt;
            opb     <= opb_nxt;
`endif
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.out       = out_r;
    assign bus.zero      = (out_r == '0);
`ifdef ALU_MULDIV_EN
    assign bus.busy      = (state == BUSY);
`else
    assign bus.busy      = 1'b0;
`endif
endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - directed self-checking bench for alu_seq
module tb_alu_seq;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   assert_cnt = 0;
    int   fail_cnt   = 0;

`ifdef ALU_MULDIV_EN
    localparam bit MD_ON  = 1'b1;
    localparam int MD_LAT = 33;
`else
    localparam bit MD_ON  = 1'b0;
    localparam int MD_LAT = 1;
`endif

    alu_seq_if #(.XLEN(32)) bus ();
    alu_seq #(.XLEN(32), .CNT_W(6)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    // Issue one request, wait for the result, then consume it. Operands are
    // scrambled right after the accept edge to show they were latched.
    task automatic issue(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output logic z, output int lat,
                         output bit hs_ok, output logic rdy_after);
        bus.op = o; bus.read1 = a; bus.read2 = b; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
        hs_ok = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0; bus.read1 = ~a; bus.read2 = ~b;
        rdy_after = bus.in_ready;
        lat = 1;
        while (!bus.out_valid && lat < 200) begin
            if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0) hs_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        res = bus.out; z = bus.zero;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.op = '0; bus.read1 = '0; bus.read2 = '0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        assert_cnt++; if (bus.in_ready !== 1'b1) begin fail_cnt++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
        assert_cnt++; if (bus.out_valid !== 1'b0) begin fail_cnt++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
        assert_cnt++; if (bus.busy !== 1'b0) begin fail_cnt++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        assert_cnt++; if (bus.out !== 32'h0) begin fail_cnt++; $display("FAIL reset_out: got %h expected 00000000", bus.out); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_base_ops();
        logic [4:0]  vop [12] = '{5'd9, 5'd7, 5'd3, 5'd4, 5'd1, 5'd2, 5'd6, 5'd5, 5'd0, 5'd8, 5'd12, 5'd9};
        logic [31:0] va  [12] = '{32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd5, 32'd1,
                                  32'h80000000, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'h0F0F0000, 32'h1234, 32'hFFFFFFFF};
        logic [31:0] vb  [12] = '{32'd1, 32'h24, 32'd1, 32'd1, 32'd7, 32'h21,
                                  32'd4, 32'hFF00FF00, 32'hFF00FF00, 32'h000000F0, 32'h5678, 32'd1};
        logic [31:0] ve  [12] = '{32'h80000000, 32'hF8000000, 32'd1, 32'd0, 32'hFFFFFFFE, 32'd2,
                                  32'h08000000, 32'h0FF00FF0, 32'hF000F000, 32'h0F0F00F0, 32'd0, 32'd0};
        logic [31:0] r; logic z; int lat; bit hs; logic rdy;
        for (int i = 0; i < 12; i++) begin
            issue(vop[i], va[i], vb[i], r, z, lat, hs, rdy);
            assert_cnt++; if (r !== ve[i]) begin fail_cnt++; $display("FAIL base_out[%0d] op=%0d: got %h expected %h", i, vop[i], r, ve[i]); end
            assert_cnt++; if (z !== (ve[i] == 32'd0)) begin fail_cnt++; $display("FAIL base_zero[%0d]: got %b expected %b", i, z, ve[i] == 32'd0); end
            assert_cnt++; if (lat != 1) begin fail_cnt++; $display("FAIL base_latency[%0d]: got %0d expected 1", i, lat); end
            assert_cnt++; if (rdy !== 1'b0) begin fail_cnt++; $display("FAIL base_in_ready_done[%0d]: got %b expected 0", i, rdy); end
        end
    endtask

    task automatic test_mul();
        logic [4:0]  vop [5] = '{5'h11, 5'h13, 5'h10, 5'h12, 5'h18};
        logic [31:0] va  [5] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'd7, 32'hFFFFFFFF, 32'd3};
        logic [31:0] vb  [5] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'd2, 32'd5};
        logic [31:0] ve  [5] = '{32'h00000000, 32'hFFFFFFFE, 32'hFFFFFFEB, 32'hFFFFFFFF, 32'h0000000F};
        logic [31:0] r, exp; logic z; int lat; bit hs; logic rdy;
        for (int i = 0; i < 5; i++) begin
            exp = MD_ON ? ve[i] : 32'd0;
            issue(vop[i], va[i], vb[i], r, z, lat, hs, rdy);
            assert_cnt++; if (r !== exp) begin fail_cnt++; $display("FAIL mul_out[%0d] op=%h: got %h expected %h", i, vop[i], r, exp); end
            assert_cnt++; if (lat != MD_LAT) begin fail_cnt++; $display("FAIL mul_latency[%0d]: got %0d expected %0d", i, lat, MD_LAT); end
            assert_cnt++; if (hs !== 1'b1) begin fail_cnt++; $display("FAIL mul_busy_in_ready[%0d]: got %b expected 1", i, hs); end
        end
    endtask

    task automatic test_div();
        logic [4:0]  vop [8] = '{5'h14, 5'h16, 5'h15, 5'h16, 5'h14, 5'h16, 5'h15, 5'h17};
        logic [31:0] va  [8] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd5, 32'd5, 32'h80000000, 32'h80000000, 32'd100, 32'd100};
        logic [31:0] vb  [8] = '{32'd2, 32'd2, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd7, 32'd7};
        logic [31:0] ve  [8] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd5, 32'h80000000, 32'd0, 32'd14, 32'd2};
        logic [31:0] r, exp; logic z; int lat, elat; bit hs; logic rdy;
        for (int i = 0; i < 8; i++) begin
            exp  = MD_ON ? ve[i] : 32'd0;
            elat = (vb[i] == 32'd0) ? 1 : MD_LAT;
            issue(vop[i], va[i], vb[i], r, z, lat, hs, rdy);
            assert_cnt++; if (r !== exp) begin fail_cnt++; $display("FAIL div_out[%0d] op=%h: got %h expected %h", i, vop[i], r, exp); end
            assert_cnt++; if (z !== (exp == 32'd0)) begin fail_cnt++; $display("FAIL div_zero[%0d]: got %b expected %b", i, z, exp == 32'd0); end
            assert_cnt++; if (lat != elat) begin fail_cnt++; $display("FAIL div_latency[%0d]: got %0d expected %0d", i, lat, elat); end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] r, exp; logic z; int lat; bit hs; logic rdy;
        exp = MD_ON ? 32'd14 : 32'd0;
        bus.op = 5'h14; bus.read1 = 32'd100; bus.read2 = 32'd7; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
        assert_cnt++; if (lat != MD_LAT) begin fail_cnt++; $display("FAIL bp_latency: got %0d expected %0d", lat, MD_LAT); end
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin bus.op = 5'd9; bus.read1 = 32'd1; bus.read2 = 32'd1; bus.in_valid = 1'b1; end
            @(posedge clk); #1;
            bus.in_valid = 1'b0;
            assert_cnt++; if (bus.out !== exp) begin fail_cnt++; $display("FAIL bp_out_stable[%0d]: got %h expected %h", i, bus.out, exp); end
            assert_cnt++; if (bus.out_valid !== 1'b1) begin fail_cnt++; $display("FAIL bp_out_valid[%0d]: got %b expected 1", i, bus.out_valid); end
            assert_cnt++; if (bus.in_ready !== 1'b0) begin fail_cnt++; $display("FAIL bp_in_ready[%0d]: got %b expected 0", i, bus.in_ready); end
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        assert_cnt++; if (bus.out_valid !== 1'b0) begin fail_cnt++; $display("FAIL bp_consumed: got out_valid %b expected 0", bus.out_valid); end
        assert_cnt++; if (bus.in_ready !== 1'b1) begin fail_cnt++; $display("FAIL bp_idle: got in_ready %b expected 1", bus.in_ready); end
        issue(5'd9, 32'd4, 32'd4, r, z, lat, hs, rdy);
        assert_cnt++; if (r !== 32'd8) begin fail_cnt++; $display("FAIL bp_next_add: got %h expected 00000008", r); end
    endtask

    task automatic test_reset_mid_op();
        logic [31:0] r; logic z; int lat; bit hs; logic rdy;
        bus.op = 5'h10; bus.read1 = 32'd1234; bus.read2 = 32'd5678; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        assert_cnt++; if (bus.busy !== MD_ON) begin fail_cnt++; $display("FAIL mid_busy_before: got %b expected %b", bus.busy, MD_ON); end
        assert_cnt++; if (bus.out_valid !== !MD_ON) begin fail_cnt++; $display("FAIL mid_out_valid_before: got %b expected %b", bus.out_valid, !MD_ON); end
        rst_n = 1'b0;
        #1;
        assert_cnt++; if (bus.out_valid !== 1'b0) begin fail_cnt++; $display("FAIL mid_reset_out_valid: got %b expected 0", bus.out_valid); end
        assert_cnt++; if (bus.busy !== 1'b0) begin fail_cnt++; $display("FAIL mid_reset_busy: got %b expected 0", bus.busy); end
        assert_cnt++; if (bus.in_ready !== 1'b1) begin fail_cnt++; $display("FAIL mid_reset_in_ready: got %b expected 1", bus.in_ready); end
        assert_cnt++; if (bus.out !== 32'd0) begin fail_cnt++; $display("FAIL mid_reset_out: got %h expected 00000000", bus.out); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        issue(5'd9, 32'd2, 32'd3, r, z, lat, hs, rdy);
        assert_cnt++; if (r !== 32'd5) begin fail_cnt++; $display("FAIL mid_after_add: got %h expected 00000005", r); end
        assert_cnt++; if (lat != 1) begin fail_cnt++; $display("FAIL mid_after_latency: got %0d expected 1", lat); end
    endtask

    initial begin
        test_reset();
        test_base_ops();
        test_mul();
        test_div();
        test_backpressure();
        test_reset_mid_op();
        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, handshaked successor to the core's combinational ALU.
- Executes the RV base ALU ops in 1 cycle, plus the M-extension multiply/divide ops iteratively, 1 bit per cycle.
- Sits in the EX stage. The pipeline stalls on in_ready/out_valid instead of assuming fixed single-cycle latency.

Parameters:
- XLEN, 32, operand/result width; power of two, >= 8. Derived localparam SHW = log2(XLEN) sets the shift-amount width.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > XLEN.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset; asynchronous and active-low
- in_valid  in  1  operation request
- in_ready  out  1  block can accept a request
- op  in  5  operation select (encoding below)
- read1  in  XLEN  operand A (rs1)
- read2  in  XLEN  operand B (rs2/imm)
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out  out  XLEN  result, registered
- zero  out  1  (out == 0), meaningful while out_valid
- busy  out  1  iterative op in progress

Behaviour:
- Op encoding when op[4]=0: AND=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, ADD=9. Codes 10-15 are reserved and produce out=0.
- Op encoding when op[4]=1: op[2:0] follows RV funct3 order: MUL=0, MULH=1, MULHSU=2, MULHU=3, DIV=4, DIVU=5, REM=6, REMU=7. op[3] is ignored.
- Reset values: state=IDLE, in_ready=1, out_valid=0, out=0, busy=0, counter=0, internal accumulators=0.
- FSM has three states: IDLE, BUSY, DONE.
- IDLE: in_ready=1. Request is accepted on in_valid&in_ready; operands and op are latched.
  - Base op: result registered on the accept edge; state -> DONE.
  - Mul op: state -> BUSY.
  - Div/rem op, divisor != 0: state -> BUSY.
  - Div/rem op, divisor == 0: result computed directly, state -> DONE.
- BUSY: busy=1, in_ready=0. Exactly XLEN iterations run, then state -> DONE.
  - Mul: shift-add on the 2*XLEN-bit product of magnitudes.
  - Div: restoring divide on magnitudes.
  - Final sign correction is applied in the last iteration cycle.
- DONE: out_valid=1, in_ready=0. out and zero are held stable until out_ready; on out_valid&out_ready, state -> IDLE.
- Latency, accept edge to out_valid high:
  - Base op: 1 cycle.
  - Mul/div: XLEN+1 cycles.
  - Divide by zero: 1 cycle.
- Throughput: no overlap. A new request is accepted only in IDLE, so the minimum spacing is 2 cycles.
- Arithmetic rules:
  - Add/sub wrap modulo 2^XLEN.
  - Shifts use read2[SHW-1:0] only.
  - SRA is arithmetic.
  - SLT/SLTU return 0 or 1, zero-extended.
- Multiply:
  - MUL returns product[XLEN-1:0].
  - MULH is signed x signed, MULHSU is signed x unsigned, MULHU is unsigned x unsigned; all three return product[2XLEN-1:XLEN].
- Divide by zero: DIV/DIVU return all ones; REM/REMU return read1.
- Signed overflow (read1 = -2^(XLEN-1), read2 = -1):
  - DIV returns read1; REM returns 0.
  - This falls out of the magnitude path; no special-case logic.
- Remainder sign follows the dividend; quotient truncates toward zero.
- Operand changes after acceptance have no effect, because inputs are latched.
- Async reset asserted mid-BUSY or mid-DONE: immediate return to reset values; the in-flight result is discarded.

Optional Feature:
- Macro: ALU_MULDIV_EN.
- Defined: M ops are executed as specified above.
- Undefined:
  - No mul/div datapath is instantiated; BUSY is unreachable; busy ties to 0.
  - Any op with op[4]=1 completes in 1 cycle with out=0.

Test Plan:
- Reset then ADD: rst_n low, then high; ADD 0x7FFFFFFF + 1 -> out_valid 1 cycle after accept, out=0x80000000, zero=0. Reset state showed in_ready=1, out_valid=0.
- SRA with excess shift bits: read1=0x80000000, read2=0x00000024 (shamt 4) -> out=0xF8000000. SLT(-1,1) -> 1; SLTU(-1,1) -> 0.
- MULH: 0xFFFFFFFF x 0xFFFFFFFF -> out=0x00000000. MULHU on the same operands -> out=0xFFFFFFFE. Each takes 33 cycles from accept to out_valid; busy=1 and in_ready=0 throughout.
- Divide cases:
  - DIV(-7,2) -> 0xFFFFFFFD; REM(-7,2) -> 0xFFFFFFFF.
  - DIVU(5,0) -> 0xFFFFFFFF in 1 cycle; REM(5,0) -> 5.
  - DIV(0x80000000, 0xFFFFFFFF) -> 0x80000000.
- Backpressure: hold out_ready=0 for 5 cycles after a DIV result -> out stable, in_ready=0, and an in_valid pulse is ignored. Result is consumed on the first out_ready=1 edge.
- Reset mid-op: pull rst_n low at iteration 10 of a MUL -> out_valid=0 and busy=0 immediately. After release, an ADD 2+3 returns 5 in 1 cycle.
